// File: rtl/seq_alu.sv
// seq_alu: registered ALU with valid/ready handshakes, N/Z/C/V flags
// and an iterative shift-add multiplier.
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic             out_err
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_NOT  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_EQ   = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_MUL  = 4'd12;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [SHW-1:0]   cnt;

  logic [WIDTH:0]   add_w;
  logic [WIDTH:0]   sub_w;
  logic [SHW-1:0]   sh;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;
  logic             alu_err;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] mul_sum;

  logic in_xfer;
  logic out_xfer;

  assign in_ready = (state == IDLE) & (~out_valid | out_ready);
  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  assign add_w = {1'b0, in_a} + {1'b0, in_b};
  // Subtract as A + ~B + 1 so carry-out reads as "no borrow"
  assign sub_w = {1'b0, in_a} + {1'b0, ~in_b}
               + {{WIDTH{1'b0}}, 1'b1};
  assign sh    = in_b[SHW-1:0];

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_err = 1'b0;
    case (in_op)
      OP_ADD: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (in_a[WIDTH-1] == in_b[WIDTH-1])
                & (add_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (in_a[WIDTH-1] != in_b[WIDTH-1])
                & (sub_w[WIDTH-1] != in_a[WIDTH-1]);
      end
      OP_NOT:  alu_res = ~in_a;
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_XOR:  alu_res = in_a ^ in_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}},
                          $signed(in_a) < $signed(in_b)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, in_a == in_b};
      OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, in_a < in_b};
      OP_SLL:  alu_res = in_a << sh;
      OP_SRL:  alu_res = in_a >> sh;
      OP_SRA:  alu_res = WIDTH'($signed(in_a) >>> sh);
      OP_MUL:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  assign alu_flags = alu_err ? 4'b0000
                   : {alu_res[WIDTH-1], alu_res == '0,
                      alu_c, alu_v};

  assign mul_sum = acc + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_flags  <= 4'b0000;
      out_err    <= 1'b0;
      mcand      <= '0;
      mplier     <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else begin
      if (out_xfer)
        out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_xfer) begin
            if (in_op == OP_MUL) begin
              state  <= BUSY;
              mcand  <= in_a;
              mplier <= in_b;
              acc    <= '0;
              cnt    <= '0;
            end else begin
              out_result <= alu_res;
              out_flags  <= alu_flags;
              out_err    <= alu_err;
              out_valid  <= 1'b1;
            end
          end
        end
        default: begin
          acc    <= mul_sum;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state      <= IDLE;
            cnt        <= '0;
            out_result <= mul_sum;
            out_flags  <= {mul_sum[WIDTH-1],
                           mul_sum == '0, 2'b00};
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed checks of seq_alu at WIDTH=8 and WIDTH=32
// against hand-computed results, flags and latencies.
module tb_seq_alu;

  logic clk;
  logic rst;

  logic       iv8, ir8, ov8, or8, err8;
  logic [7:0] a8, b8, res8;
  logic [3:0] op8, fl8;

  logic        iv32, ir32, ov32, or32, err32;
  logic [31:0] a32, b32, res32;
  logic [3:0]  op32, fl32;

  int checks;
  int errors;
  int n;

  seq_alu #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst),
    .in_valid(iv8), .in_ready(ir8),
    .in_a(a8), .in_b(b8), .in_op(op8),
    .out_valid(ov8), .out_ready(or8),
    .out_result(res8), .out_flags(fl8), .out_err(err8)
  );

  seq_alu #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(iv32), .in_ready(ir32),
    .in_a(a32), .in_b(b32), .in_op(op32),
    .out_valid(ov32), .out_ready(or32),
    .out_result(res32), .out_flags(fl32), .out_err(err32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go8(input logic [7:0] a,
                     input logic [7:0] b,
                     input logic [3:0] op);
    a8 = a; b8 = b; op8 = op; iv8 = 1'b1;
    step();
    iv8 = 1'b0;
  endtask

  task automatic go32(input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [3:0] op);
    a32 = a; b32 = b; op32 = op; iv32 = 1'b1;
    step();
    iv32 = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    iv8 = 0; a8 = 0; b8 = 0; op8 = 0; or8 = 1;
    iv32 = 0; a32 = 0; b32 = 0; op32 = 0; or32 = 1;
    step();
    step();
    chk("rst_valid", ov8, 0);
    chk("rst_result", res8, 0);
    chk("rst_flags", fl8, 0);
    chk("rst_err", err8, 0);
    chk("rst_ready", ir8, 1);
    rst = 1'b1;

    go8(8'h7F, 8'h01, 4'd0);
    chk("add_valid", ov8, 1);
    chk("add_res", res8, 8'h80);
    chk("add_flags", fl8, 4'b1001);

    go8(8'h05, 8'h05, 4'd1);
    chk("sub_res", res8, 8'h00);
    chk("sub_flags", fl8, 4'b0110);

    go8(8'd13, 8'd11, 4'd12);
    a8 = 8'h00; b8 = 8'h00;
    chk("mul_rdy_e1", ir8, 0);
    for (int i = 2; i <= 8; i++) begin
      step();
      chk("mul_busy_rdy", ir8, 0);
      chk("mul_busy_vld", ov8, 0);
    end
    step();
    chk("mul_vld_e9", ov8, 1);
    chk("mul_res", res8, 8'h8F);
    chk("mul_flags", fl8, 4'b1000);
    chk("mul_rdy_done", ir8, 1);

    go8(8'hFF, 8'hFF, 4'd12);
    n = 0;
    while (!ov8 && n < 40) begin
      step();
      n++;
    end
    chk("mulff_lat", n, 8);
    chk("mulff_res", res8, 8'h01);
    chk("mulff_flags", fl8, 4'b0000);

    step();
    chk("drain_vld", ov8, 0);
    or8 = 1'b0;
    go8(8'hF0, 8'h3C, 4'd3);
    chk("and_res", res8, 8'h30);
    chk("and_rdy", ir8, 0);
    a8 = 8'hAA; b8 = 8'hFF; op8 = 4'd5; iv8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("hold_vld", ov8, 1);
      chk("hold_res", res8, 8'h30);
      chk("hold_rdy", ir8, 0);
    end
    or8 = 1'b1;
    #1;
    chk("rel_rdy", ir8, 1);
    step();
    iv8 = 1'b0;
    chk("xor_vld", ov8, 1);
    chk("xor_res", res8, 8'h55);
    step();
    chk("xor_drain_vld", ov8, 0);
    chk("xor_drain_res", res8, 8'h55);

    go8(8'h80, 8'h0B, 4'd11);
    chk("sra_res", res8, 8'hF0);
    chk("sra_flags", fl8, 4'b1000);
    go8(8'h80, 8'h03, 4'd10);
    chk("srl_res", res8, 8'h10);
    go8(8'h81, 8'h08, 4'd9);
    chk("sll0_res", res8, 8'h81);
    go8(8'hFF, 8'h01, 4'd6);
    chk("slt_res", res8, 8'h01);
    go8(8'hFF, 8'h01, 4'd8);
    chk("sltu_res", res8, 8'h00);
    chk("sltu_flags", fl8, 4'b0100);
    go8(8'h5A, 8'h5A, 4'd7);
    chk("eq_res", res8, 8'h01);

    go8(8'd13, 8'd11, 4'd12);
    step();
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mrst_vld", ov8, 0);
    chk("mrst_rdy", ir8, 1);
    chk("mrst_res", res8, 0);
    go8(8'h02, 8'h03, 4'd0);
    chk("post_rst_vld", ov8, 1);
    chk("post_rst_res", res8, 8'h05);

    go8(8'hFF, 8'h12, 4'd14);
    chk("ill_res", res8, 8'h00);
    chk("ill_flags", fl8, 4'b0000);
    chk("ill_err", err8, 1);
    go8(8'h0F, 8'h00, 4'd2);
    chk("not_res", res8, 8'hF0);
    chk("not_err", err8, 0);

    go32(32'h7FFF_FFFF, 32'h1, 4'd0);
    chk("add32_res", res32, 32'h8000_0000);
    chk("add32_flags", fl32, 4'b1001);
    go32(32'h0000_FFFF, 32'h0000_FFFF, 4'd12);
    n = 0;
    while (!ov32 && n < 100) begin
      step();
      n++;
    end
    chk("mul32_lat", n, 32);
    chk("mul32_res", res32, 32'hFFFE_0001);
    chk("mul32_flags", fl32, 4'b1000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
